// File: rtl/add_test_4_pcore.sv
// Dual-rail encoded 16-bit wrap-around adder with a registered dual-rail sum.
// Each data bit travels as {false_rail, true_rail}: 01 = 1, 10 = 0, 00/11 invalid.

module add_test_4_pcore_cell (
    input  logic a_t,
    input  logic a_f,
    input  logic b_t,
    input  logic b_f,
    input  logic c_t,
    input  logic c_f,
    output logic s_t,
    output logic s_f,
    output logic co_t,
    output logic co_f
);
    // Both rails are built as sums of minterms so each rail only fires on valid codes.
    assign s_t  = (a_t & b_f & c_f) | (a_f & b_t & c_f) | (a_f & b_f & c_t) | (a_t & b_t & c_t);
    assign s_f  = (a_f & b_f & c_f) | (a_t & b_t & c_f) | (a_t & b_f & c_t) | (a_f & b_t & c_t);
    assign co_t = (a_t & b_t) | (a_t & c_t) | (b_t & c_t);
    assign co_f = (a_f & b_f) | (a_f & c_f) | (b_f & c_f);
endmodule

module add_test_4_pcore #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*N-1:0] r1_p,
    input  logic [2*N-1:0] r2_p,
    output logic [2*N-1:0] r_result_p
);
    logic [N:0]     c_t;
    logic [N:0]     c_f;
    logic [2*N-1:0] sum_p;
    logic [N-1:0]   pair_ok;
    logic           valid_all;
    logic [2*N-1:0] result_d;
    logic [2*N-1:0] result_q;

    // Carry-in is a dual-rail logic 0.
    assign c_t[0] = 1'b0;
    assign c_f[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        add_test_4_pcore_cell u_cell (
            .a_t  (r1_p[2*i]),
            .a_f  (r1_p[2*i+1]),
            .b_t  (r2_p[2*i]),
            .b_f  (r2_p[2*i+1]),
            .c_t  (c_t[i]),
            .c_f  (c_f[i]),
            .s_t  (sum_p[2*i]),
            .s_f  (sum_p[2*i+1]),
            .co_t (c_t[i+1]),
            .co_f (c_f[i+1])
        );
        assign pair_ok[i] = (r1_p[2*i] ^ r1_p[2*i+1]) & (r2_p[2*i] ^ r2_p[2*i+1]);
    end

    assign valid_all = &pair_ok;

    always_comb begin
        result_d = result_q;
        if (valid_all) begin
            result_d = sum_p;
        end
    end

    // Reset value is enc(0) so the output is a valid code from the start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= {N{2'b10}};
        end else begin
            result_q <= result_d;
        end
    end

    assign r_result_p = result_q;

    // Carry-out of the top bit is intentionally unused (mod 2^N sum).
    logic unused_carry;
    assign unused_carry = c_t[N] ^ c_f[N];
endmodule

// File: tb/tb_add_test_4_pcore.sv
// Directed bench for the dual-rail adder: reset, arithmetic, wrap, invalid-code hold, async reset.

module tb_add_test_4_pcore;
    logic        clk;
    logic        rst;
    logic [31:0] r1_p;
    logic [31:0] r2_p;
    logic [31:0] r_result_p;

    int n_chk;
    int n_err;

    add_test_4_pcore dut (
        .clk        (clk),
        .rst        (rst),
        .r1_p       (r1_p),
        .r2_p       (r2_p),
        .r_result_p (r_result_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [15:0] v);
        logic [31:0] p;
        for (int i = 0; i < 16; i++) begin
            p[2*i]   = v[i];
            p[2*i+1] = ~v[i];
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive operands between edges, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        r1_p = a;
        r2_p = b;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] va [12];
    logic [15:0] vb [12];
    logic [31:0] bad;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        r1_p  = enc(16'd0);
        r2_p  = enc(16'd0);

        // 1: async reset before any clock edge
        #2 rst = 1'b1;
        #1 chk("reset_async", r_result_p, 32'hAAAA_AAAA);
        @(posedge clk);
        #1 chk("reset_held_over_edge", r_result_p, 32'hAAAA_AAAA);
        @(negedge clk);
        rst = 1'b0;

        // 2: 2 + 4
        step(32'hAAAA_AAA6, 32'hAAAA_AA9A);
        chk("add_2_4", r_result_p, 32'hAAAA_AA96);

        // 3: 0x8888 + 0x8888 = 0x1110 (bit16 dropped)
        step(enc(16'h8888), enc(16'h8888));
        chk("add_8888x2", r_result_p, enc(16'h1110));

        // 4: wrap cases
        step(enc(16'hFFFF), enc(16'h0001));
        chk("wrap_ffff_1", r_result_p, 32'hAAAA_AAAA);
        step(enc(16'hFFFF), enc(16'hFFFF));
        chk("wrap_ffff_ffff", r_result_p, enc(16'hFFFE));

        // 5: invalid codes hold the previous result
        step(enc(16'd2), enc(16'd4));
        chk("load_6", r_result_p, enc(16'd6));
        bad = enc(16'd100);
        bad[7:6] = 2'b11;
        step(enc(16'd9), bad);
        chk("hold_on_11", r_result_p, enc(16'd6));
        bad = enc(16'd100);
        bad[7:6] = 2'b00;
        step(enc(16'd9), bad);
        chk("hold_on_00", r_result_p, enc(16'd6));
        bad = enc(16'd7);
        bad[31:30] = 2'b00;
        step(bad, enc(16'd1));
        chk("hold_on_a_top_00", r_result_p, enc(16'd6));

        // 6: sweep of pairs with A<10000, B<20000
        va = '{16'd0, 16'd1, 16'd9999, 16'd1234, 16'd5000, 16'd4095,
               16'd7777, 16'd255, 16'd8191, 16'd3, 16'd6000, 16'd9000};
        vb = '{16'd0, 16'd19999, 16'd19999, 16'd4321, 16'd15000, 16'd1,
               16'd2222, 16'd256, 16'd8193, 16'd12345, 16'd14000, 16'd11000};
        for (int k = 0; k < 12; k++) begin
            step(enc(va[k]), enc(vb[k]));
            chk($sformatf("sweep_%0d", k), r_result_p, enc(va[k] + vb[k]));
        end

        // mid-cycle reset overrides the pending capture
        @(negedge clk);
        r1_p = enc(16'd1500);
        r2_p = enc(16'd2500);
        #2 rst = 1'b1;
        #1 chk("rst_mid_immediate", r_result_p, 32'hAAAA_AAAA);
        @(posedge clk);
        #1 chk("rst_mid_edge_ignored", r_result_p, 32'hAAAA_AAAA);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("after_rst_capture", r_result_p, enc(16'd4000));

        // operand changes between edges have no effect until the next edge
        @(negedge clk);
        r1_p = enc(16'd10);
        r2_p = enc(16'd20);
        #1 chk("no_comb_path", r_result_p, enc(16'd4000));
        @(posedge clk);
        #1 chk("next_edge_30", r_result_p, enc(16'd30));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
